// File: rtl/score_sound_controller.sv
// Game-session controller: IDLE/PLAY/FAIL sequencing, per-channel pass scoring into a
// saturating BCD score, persistent high score, and pass/fail square-wave sound effects.
module score_sound_controller #(
   parameter int NUM_CH    = 3,
   parameter int DIGITS    = 4,
   parameter int PASS_HALF = 41666,
   parameter int FAIL_HALF = 125000,
   parameter int PASS_DUR  = 5000000,
   parameter int FAIL_DUR  = 50000000
) (
   input  logic                  ClkPort,
   input  logic                  Reset_n,
   input  logic                  tick,
   input  logic                  start,
   input  logic [NUM_CH-1:0]     hit,
   input  logic [NUM_CH-1:0]     pass,
   input  logic                  hit_ground,
   output logic [1:0]            state_o,
   output logic                  fail,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   high_bcd,
   output logic                  new_high,
   output logic                  audio_out
);

   localparam int SW       = 4 * DIGITS;
   localparam int NW       = $clog2(NUM_CH + 1);
   localparam int PEND_W   = 8;
   localparam int MAX_HALF = (PASS_HALF > FAIL_HALF) ? PASS_HALF : FAIL_HALF;
   localparam int CNT_W    = $clog2(2 * MAX_HALF);
   localparam int MAX_DUR  = (PASS_DUR > FAIL_DUR) ? PASS_DUR : FAIL_DUR;
   localparam int DUR_W    = $clog2(MAX_DUR + 1);
   localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_FAIL = 2'b10
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [NUM_CH-1:0]   pass_q;
   logic [PEND_W-1:0]   pend;
   logic [PEND_W-1:0]   pend_nxt;
   logic [PEND_W:0]     pend_sum;
   logic                cmp_done;
   logic [SW-1:0]       score;
   logic [SW-1:0]       high;
   logic                new_high_r;
   logic [DUR_W-1:0]    dur;
   logic [CNT_W-1:0]    tone_cnt;
   logic                tone_fail;

   logic                crash;
   logic                play_tick;
   logic                fail_entry;
   logic                restart;
   logic                drain;
   logic [NUM_CH-1:0]   new_pass;
   logic [NW-1:0]       n_new;
   logic                fail_sound_active;
   logic                pass_sound;
   logic [CNT_W-1:0]    half;
   logic [CNT_W-1:0]    wrap;

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign crash      = (|hit) | hit_ground;
   assign play_tick  = (state == S_PLAY) && tick;
   assign fail_entry = play_tick && crash;
   assign restart    = (state == S_FAIL) && start && cmp_done;
   assign drain      = (pend != '0) && ((state == S_PLAY) || (state == S_FAIL));

   // Passes seen on a crashing tick are discarded along with any sound they would start.
   always_comb begin
      new_pass = '0;
      n_new    = '0;
      if (play_tick && !crash) begin
         new_pass = pass & ~pass_q;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         n_new = n_new + NW'(new_pass[i]);
      end
   end

   always_comb begin
      pend_sum = {1'b0, pend} + (PEND_W+1)'(n_new) - (PEND_W+1)'(drain);
      pend_nxt = pend_sum[PEND_W] ? {PEND_W{1'b1}} : pend_sum[PEND_W-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_PLAY;
         S_PLAY:  if (fail_entry) state_nxt = S_FAIL;
         S_FAIL:  if (restart) state_nxt = S_PLAY;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Score drains one unit per cycle from pend; the high-score compare waits for an empty pend.
   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         pass_q     <= '0;
         pend       <= '0;
         score      <= '0;
         high       <= '0;
         new_high_r <= 1'b0;
         cmp_done   <= 1'b0;
      end else if (restart) begin
         pass_q     <= '0;
         pend       <= '0;
         score      <= '0;
         new_high_r <= 1'b0;
         cmp_done   <= 1'b0;
      end else begin
         if (play_tick) begin
            pass_q <= pass;
         end
         pend <= pend_nxt;
         if (drain && (score != ALL_NINES)) begin
            score <= bcd_inc(score);
         end
         if ((state == S_FAIL) && (pend == '0) && !cmp_done) begin
            cmp_done <= 1'b1;
            if (score > high) begin
               high       <= score;
               new_high_r <= 1'b1;
            end
         end
      end
   end

   assign fail_sound_active = (dur != '0) && tone_fail;
   assign pass_sound        = (n_new != '0) && !fail_sound_active;
   assign half              = tone_fail ? CNT_W'(FAIL_HALF) : CNT_W'(PASS_HALF);
   assign wrap              = tone_fail ? CNT_W'(2 * FAIL_HALF - 1) : CNT_W'(2 * PASS_HALF - 1);

   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         dur       <= '0;
         tone_cnt  <= '0;
         tone_fail <= 1'b0;
      end else if (fail_entry) begin
         dur       <= DUR_W'(FAIL_DUR);
         tone_cnt  <= '0;
         tone_fail <= 1'b1;
      end else if (pass_sound) begin
         dur       <= DUR_W'(PASS_DUR);
         tone_cnt  <= '0;
         tone_fail <= 1'b0;
      end else if (dur != '0) begin
         dur      <= dur - DUR_W'(1);
         tone_cnt <= (tone_cnt == wrap) ? '0 : tone_cnt + CNT_W'(1);
      end
   end

   assign state_o   = state;
   assign fail      = (state == S_FAIL);
   assign score_bcd = score;
   assign high_bcd  = high;
   assign new_high  = new_high_r;
   assign audio_out = (dur != '0) && (tone_cnt < half);

endmodule

// File: tb/tb_score_sound_controller.sv
// Directed bench for score_sound_controller: vector table for the scoring/state flow,
// hand-written sequences for tone timing and mid-game reset.
module tb_score_sound_controller;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       start;
   logic [2:0] hit;
   logic [2:0] pass;
   logic       hit_ground;
   logic [1:0] state_o;
   logic       fail;
   logic [7:0] score_bcd;
   logic [7:0] high_bcd;
   logic       new_high;
   logic       audio_out;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       tick;
      logic       start;
      logic [2:0] hit;
      logic [2:0] pass;
      logic       hg;
      logic [1:0] st;
      logic [7:0] score;
      logic [7:0] high;
      logic       nh;
   } vec_t;

   vec_t vecs[$];

   score_sound_controller #(
      .NUM_CH(3), .DIGITS(2), .PASS_HALF(4), .FAIL_HALF(8), .PASS_DUR(40), .FAIL_DUR(100)
   ) dut (
      .ClkPort(clk),
      .Reset_n(rst_n),
      .tick(tick),
      .start(start),
      .hit(hit),
      .pass(pass),
      .hit_ground(hit_ground),
      .state_o(state_o),
      .fail(fail),
      .score_bcd(score_bcd),
      .high_bcd(high_bcd),
      .new_high(new_high),
      .audio_out(audio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic t, input logic s, input logic [2:0] h,
                                input logic [2:0] p, input logic g);
      tick       = t;
      start      = s;
      hit        = h;
      pass       = p;
      hit_ground = g;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic passEdge(input logic [2:0] mask);
      applyStimulus(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'b000, mask, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0, 3'b000, mask, 1'b0);
   endtask

   task automatic runVectors(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         applyStimulus(vecs[i].tick, vecs[i].start, vecs[i].hit, vecs[i].pass, vecs[i].hg);
         checkOutput($sformatf("v%0d state", i), state_o, vecs[i].st);
         checkOutput($sformatf("v%0d fail", i), fail, vecs[i].st == 2'b10);
         checkOutput($sformatf("v%0d score", i), score_bcd, vecs[i].score);
         checkOutput($sformatf("v%0d high", i), high_bcd, vecs[i].high);
         checkOutput($sformatf("v%0d new_high", i), new_high, vecs[i].nh);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " state"}, state_o, 0);
      checkOutput({tag, " fail"}, fail, 0);
      checkOutput({tag, " score"}, score_bcd, 0);
      checkOutput({tag, " high"}, high_bcd, 0);
      checkOutput({tag, " new_high"}, new_high, 0);
      checkOutput({tag, " audio"}, audio_out, 0);
   endtask

   initial begin
      //                 tick  start hit     pass    hg    state  score  high   nh
      vecs.push_back('{1'b1, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0}); // 0 idle ignores
      vecs.push_back('{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0}); // 1 start
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 8'h09, 8'h00, 1'b0}); // 2
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 2'b01, 8'h09, 8'h00, 1'b0}); // 3 two edges
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 2'b01, 8'h10, 8'h00, 1'b0}); // 4
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 2'b01, 8'h11, 8'h00, 1'b0}); // 5
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b011, 1'b0, 2'b01, 8'h11, 8'h00, 1'b0}); // 6
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 8'h98, 8'h00, 1'b0}); // 7
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 2'b01, 8'h98, 8'h00, 1'b0}); // 8
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 8'h99, 8'h00, 1'b0}); // 9
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 2'b01, 8'h99, 8'h00, 1'b0}); // 10
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 8'h99, 8'h00, 1'b0}); // 11 saturate
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 2'b01, 8'h99, 8'h00, 1'b0}); // 12
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 8'h99, 8'h00, 1'b0}); // 13
      vecs.push_back('{1'b1, 1'b0, 3'b010, 3'b001, 1'b0, 2'b10, 8'h99, 8'h00, 1'b0}); // 14 hit
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'b10, 8'h99, 8'h99, 1'b1}); // 15
      vecs.push_back('{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'b01, 8'h00, 8'h99, 1'b0}); // 16 restart
      vecs.push_back('{1'b1, 1'b1, 3'b000, 3'b101, 1'b0, 2'b01, 8'h00, 8'h99, 1'b0}); // 17
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b101, 1'b0, 2'b01, 8'h01, 8'h99, 1'b0}); // 18
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b101, 1'b0, 2'b01, 8'h02, 8'h99, 1'b0}); // 19
      vecs.push_back('{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 2'b10, 8'h02, 8'h99, 1'b0}); // 20 ground
      vecs.push_back('{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'b10, 8'h02, 8'h99, 1'b0}); // 21 too early
      vecs.push_back('{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'b01, 8'h00, 8'h99, 1'b0}); // 22
      vecs.push_back('{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 8'h00, 8'h99, 1'b0}); // 23

      tick = 1'b0; start = 1'b0; hit = 3'b000; pass = 3'b000; hit_ground = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      runVectors(0, 1);

      // Single pass edge, then pass held across further ticks while the pass tone plays.
      applyStimulus(1'b1, 1'b0, 3'b000, 3'b001, 1'b0);
      for (int i = 0; i < 44; i++) begin
         checkOutput($sformatf("pass_tone[%0d]", i), audio_out, (i < 40) && ((i % 8) < 4));
         applyStimulus((i < 8) && (i % 2 == 0), 1'b0, 3'b000, 3'b001, 1'b0);
      end
      checkOutput("held_pass_once", score_bcd, 8'h01);

      repeat (8) passEdge(3'b001);
      runVectors(2, 6);
      repeat (29) passEdge(3'b111);
      runVectors(7, 14);

      // Fail tone starts on the edge that entered FAIL.
      for (int i = 0; i < 104; i++) begin
         checkOutput($sformatf("fail_tone[%0d]", i), audio_out, (i < 100) && ((i % 16) < 8));
         applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      end
      runVectors(15, 23);

      applyStimulus(1'b1, 1'b0, 3'b000, 3'b011, 1'b0);
      checkOutput("pass_snd_on", audio_out, 1);
      checkOutput("pend2_score", score_bcd, 8'h00);
      tick = 1'b0; pass = 3'b000;
      #3 rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         checkOutput($sformatf("post_reset_audio[%0d]", i), audio_out, 0);
         applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      end
      checkAllZero("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_sound_controller.md
Name: score_sound_controller

Overview:
- Parametrised game-session controller for the VGA game top level; successor to the inline fail/points/tone logic.
- Owns the IDLE/PLAY/FAIL state machine, an N-channel obstacle pass/hit interface and a DIGITS-wide BCD score.
- Keeps a persistent high score and generates distinct pass and fail sound effects.
- Outputs drive the seven-segment scanner, the red fail screen and audioOut.

Parameters:
NUM_CH, 3, number of obstacle channels (1..9)
DIGITS, 4, BCD score digits
PASS_HALF, 41666, pass-tone half-period in clocks (1.2 kHz at 100 MHz)
FAIL_HALF, 125000, fail-tone half-period in clocks (400 Hz)
PASS_DUR, 5000000, pass-sound length in clocks
FAIL_DUR, 50000000, fail-sound length in clocks

Ports:
ClkPort  in  1  system clock, 100 MHz
Reset_n  in  1  asynchronous active-low reset
tick  in  1  one-ClkPort-cycle game-step strobe (movement rate)
start  in  1  start/restart request, level
hit  in  NUM_CH  per-channel collision, level
pass  in  NUM_CH  per-channel bird-inside-gap-at-pipe-centre, level
hit_ground  in  1  ground collision, level
state_o  out  2  00 IDLE, 01 PLAY, 10 FAIL
fail  out  1  1 while in FAIL
score_bcd  out  4*DIGITS  current score, BCD, digit 0 in LSBs
high_bcd  out  4*DIGITS  high score, BCD
new_high  out  1  last game set a new high score
audio_out  out  1  square-wave speaker drive

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs and registers are 0; state is IDLE.
- hit, pass and hit_ground are sampled only on cycles where tick=1.
- IDLE:
  - score is held at 0.
  - start=1 on any cycle -> PLAY on the next cycle.
- PLAY, on a tick cycle:
  - any hit bit or hit_ground -> FAIL. pass bits sampled on that same tick are ignored.
  - otherwise, a channel counts as passed on the rising edge of its sampled pass: pass[i]=1 now and pass_q[i]=0 at the previous tick. pass_q updates every tick in PLAY.
  - the count of new passes (0..NUM_CH) is added to the pending register pend.
  - start is ignored in PLAY.
- Score drain:
  - every cycle with pend>0, in PLAY or FAIL: pend decrements by 1 and score_bcd increments by 1 in BCD, carry rippling across digits.
  - tick and drain in the same cycle: pend <= pend + n - 1.
  - score saturates at all-9s; pend keeps draining while score holds.
- FAIL:
  - fail=1.
  - once pend==0 (one-shot per game): if score > high, high <= score and new_high <= 1.
  - start=1 is honoured only after that compare is done. It moves to PLAY and clears score, pend, pass_q, new_high and the compare flag.
  - high_bcd survives restarts; only Reset_n clears it.
- Sound:
  - on a PLAY tick with n>0 and no FAIL pending: duration <= PASS_DUR, tone select = pass, tone counter <= 0.
  - on entry to FAIL: duration <= FAIL_DUR, tone select = fail, tone counter <= 0.
  - a pass sound never preempts an active fail sound. A fail sound always preempts a pass sound.
  - tone counter counts 0..2*HALF-1 and wraps.
  - audio_out = (duration>0) & (tone counter < HALF).
  - duration decrements to 0 and stops.
- Reset_n asserted mid-game, including mid-drain or mid-sound: everything returns to 0 and IDLE immediately, with no glitch pulse on audio_out afterwards.

Test Plan:
Bench overrides: NUM_CH=3, DIGITS=2, PASS_HALF=4, FAIL_HALF=8, PASS_DUR=40, FAIL_DUR=100.

1. Reset, start pulse, then pass=001 held for 5 ticks -> score_bcd=0x01 (counted once); audio_out toggles every 4 clocks for 40 clocks.
2. From score 0x09, pass goes 000->011 on one tick -> pend=2, then score 0x10 and 0x11 on consecutive cycles.
3. Score 0x98, then three single-channel pass edges -> score 0x99, stays 0x99, pend returns to 0.
4. Tick with hit=010 and pass=001 together -> state_o=10, score unchanged, high=score, new_high=1; audio_out period 16 clocks for 100 clocks.
5. Second game scoring below the high score, then hit_ground -> high_bcd unchanged, new_high=0; start in FAIL -> PLAY with score 0.
6. Reset_n low during a pass sound with pend=2 -> all outputs 0, IDLE; audio_out stays 0 after release.
